// File: rtl/branch_predictor.sv
// Direct-mapped BTB + 2-bit counter BHT with a registered, 1-cycle lookup.
// Define BPU_FWD_EN to forward a same-cycle update into a lookup of the same index.
module branch_predictor #(
    parameter int unsigned ENTRIES = 32,
    parameter int unsigned IDX_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_pc,
    input  logic        stall,
    output logic        pred_valid,
    output logic        pre_is_branch_taken,
    output logic [31:0] pre_branch_addr,
    input  logic        update_en,
    input  logic [31:0] update_pc,
    input  logic        taken_or_not_actual,
    input  logic [31:0] branch_actual_addr,
    input  logic        branch_flush
);

    localparam int unsigned TAG_W = 30 - IDX_W;

    // Table storage
    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    // Registered prediction outputs
    logic        pred_valid_q, pred_valid_d;
    logic        taken_q, taken_d;
    logic [31:0] addr_q, addr_d;

    logic [IDX_W-1:0] fetch_idx, upd_idx;
    logic [TAG_W-1:0] fetch_tag, upd_tag;

    assign fetch_idx = fetch_pc[IDX_W+1:2];
    assign fetch_tag = fetch_pc[31:IDX_W+2];
    assign upd_idx   = update_pc[IDX_W+1:2];
    assign upd_tag   = update_pc[31:IDX_W+2];

    // Byte-offset bits never take part in indexing or tagging.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{fetch_pc[1:0], update_pc[1:0]};

    // ------------------------------------------------------------------
    // Update path: compute the entry as it will look after this cycle
    // ------------------------------------------------------------------
    logic             upd_hit;
    logic             upd_we;
    logic             upd_valid_n;
    logic [TAG_W-1:0] upd_tag_n;
    logic [31:0]      upd_target_n;
    logic [1:0]       upd_ctr_n;

    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    always_comb begin
        upd_we       = 1'b0;
        upd_valid_n  = valid_q[upd_idx];
        upd_tag_n    = tag_q[upd_idx];
        upd_target_n = target_q[upd_idx];
        upd_ctr_n    = ctr_q[upd_idx];
        if (update_en) begin
            if (taken_or_not_actual) begin
                upd_we       = 1'b1;
                upd_valid_n  = 1'b1;
                upd_tag_n    = upd_tag;
                upd_target_n = branch_actual_addr;
                if (upd_hit) begin
                    upd_ctr_n = (ctr_q[upd_idx] == 2'b11) ? 2'b11 : ctr_q[upd_idx] + 2'd1;
                end else begin
                    upd_ctr_n = 2'b10;
                end
            end else if (upd_hit) begin
                upd_we    = 1'b1;
                upd_ctr_n = (ctr_q[upd_idx] == 2'b00) ? 2'b00 : ctr_q[upd_idx] - 2'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Lookup path
    // ------------------------------------------------------------------
    logic             lk_valid;
    logic [TAG_W-1:0] lk_tag;
    logic [31:0]      lk_target;
    logic [1:0]       lk_ctr;
    logic             lk_hit;
    logic             lk_taken;
    logic [31:0]      lk_addr;

    always_comb begin
        lk_valid  = valid_q[fetch_idx];
        lk_tag    = tag_q[fetch_idx];
        lk_target = target_q[fetch_idx];
        lk_ctr    = ctr_q[fetch_idx];
`ifdef BPU_FWD_EN
        if (upd_we && (upd_idx == fetch_idx)) begin
            lk_valid  = upd_valid_n;
            lk_tag    = upd_tag_n;
            lk_target = upd_target_n;
            lk_ctr    = upd_ctr_n;
        end
`endif
    end

    assign lk_hit   = lk_valid && (lk_tag == fetch_tag);
    assign lk_taken = lk_hit && lk_ctr[1];
    assign lk_addr  = lk_taken ? lk_target : fetch_pc + 32'd4;

    // Flush beats stall, stall beats a new lookup.
    always_comb begin
        pred_valid_d = pred_valid_q;
        taken_d      = taken_q;
        addr_d       = addr_q;
        if (branch_flush) begin
            pred_valid_d = 1'b0;
            taken_d      = 1'b0;
        end else if (!stall) begin
            pred_valid_d = fetch_valid;
            if (fetch_valid) begin
                taken_d = lk_taken;
                addr_d  = lk_addr;
            end else begin
                taken_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pred_valid_q <= 1'b0;
            taken_q      <= 1'b0;
            addr_q       <= 32'd0;
        end else begin
            pred_valid_q <= pred_valid_d;
            taken_q      <= taken_d;
            addr_q       <= addr_d;
        end
    end

    // Tag and target need no reset: they are only consulted behind a valid bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b01;
            end
        end else if (upd_we) begin
            valid_q[upd_idx]  <= upd_valid_n;
            tag_q[upd_idx]    <= upd_tag_n;
            target_q[upd_idx] <= upd_target_n;
            ctr_q[upd_idx]    <= upd_ctr_n;
        end
    end

    assign pred_valid          = pred_valid_q;
    assign pre_is_branch_taken = taken_q;
    assign pre_branch_addr     = addr_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector bench for branch_predictor; expectations are hand-computed.
module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        stall;
    logic        pred_valid;
    logic        pre_is_branch_taken;
    logic [31:0] pre_branch_addr;
    logic        update_en;
    logic [31:0] update_pc;
    logic        taken_or_not_actual;
    logic [31:0] branch_actual_addr;
    logic        branch_flush;

    int n_checks;
    int n_fails;

    branch_predictor #(
        .ENTRIES(32),
        .IDX_W  (5)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .fetch_valid        (fetch_valid),
        .fetch_pc           (fetch_pc),
        .stall              (stall),
        .pred_valid         (pred_valid),
        .pre_is_branch_taken(pre_is_branch_taken),
        .pre_branch_addr    (pre_branch_addr),
        .update_en          (update_en),
        .update_pc          (update_pc),
        .taken_or_not_actual(taken_or_not_actual),
        .branch_actual_addr (branch_actual_addr),
        .branch_flush       (branch_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc);
        fetch_valid = 1'b1;
        fetch_pc    = pc;
        step();
        fetch_valid = 1'b0;
    endtask

    task automatic update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        update_en           = 1'b1;
        update_pc           = pc;
        taken_or_not_actual = tk;
        branch_actual_addr  = tgt;
        step();
        update_en = 1'b0;
    endtask

    task automatic check_pred(input string tag, input logic tk, input logic [31:0] addr);
        check_val({tag, "_valid"}, {31'd0, pred_valid}, 32'd1);
        check_val({tag, "_taken"}, {31'd0, pre_is_branch_taken}, {31'd0, tk});
        check_val({tag, "_addr"}, pre_branch_addr, addr);
    endtask

    initial begin
        n_checks            = 0;
        n_fails             = 0;
        rst                 = 1'b1;
        fetch_valid         = 1'b0;
        fetch_pc            = 32'd0;
        stall               = 1'b0;
        update_en           = 1'b0;
        update_pc           = 32'd0;
        taken_or_not_actual = 1'b0;
        branch_actual_addr  = 32'd0;
        branch_flush        = 1'b0;

        step();
        step();
        check_val("rst_valid", {31'd0, pred_valid}, 32'd0);
        check_val("rst_taken", {31'd0, pre_is_branch_taken}, 32'd0);
        check_val("rst_addr", pre_branch_addr, 32'd0);
        rst = 1'b0;

        // Cold miss
        fetch(32'h1C00_0000);
        check_pred("cold", 1'b0, 32'h1C00_0004);

        // Allocate: counter 10 -> taken
        update(32'h1C00_0010, 1'b1, 32'h1C00_0100);
        check_val("idle_valid", {31'd0, pred_valid}, 32'd0);
        fetch(32'h1C00_0010);
        check_pred("alloc", 1'b1, 32'h1C00_0100);

        // Decrement 10 -> 01 -> 00 -> 00
        update(32'h1C00_0010, 1'b0, 32'h0);
        fetch(32'h1C00_0010);
        check_pred("dec1", 1'b0, 32'h1C00_0014);
        update(32'h1C00_0010, 1'b0, 32'h0);
        fetch(32'h1C00_0010);
        check_pred("dec2", 1'b0, 32'h1C00_0014);
        update(32'h1C00_0010, 1'b0, 32'h0);
        fetch(32'h1C00_0010);
        check_pred("dec_sat", 1'b0, 32'h1C00_0014);

        // 00 -> 01 (still not taken) -> 10 (taken); proves 00 saturated
        update(32'h1C00_0010, 1'b1, 32'h1C00_0100);
        fetch(32'h1C00_0010);
        check_pred("inc1", 1'b0, 32'h1C00_0014);
        update(32'h1C00_0010, 1'b1, 32'h1C00_0100);
        fetch(32'h1C00_0010);
        check_pred("inc2", 1'b1, 32'h1C00_0100);

        // Same index, different tag
        fetch(32'h1C00_0090);
        check_pred("alias", 1'b0, 32'h1C00_0094);

        // Stall holds outputs for 3 cycles despite a new fetch PC
        fetch_valid = 1'b1;
        fetch_pc    = 32'h1C00_0010;
        step();
        check_pred("pre_stall", 1'b1, 32'h1C00_0100);
        stall    = 1'b1;
        fetch_pc = 32'h1C00_0000;
        for (int i = 0; i < 3; i++) begin
            step();
            check_pred($sformatf("stall%0d", i), 1'b1, 32'h1C00_0100);
        end
        branch_flush = 1'b1;
        step();
        branch_flush = 1'b0;
        stall        = 1'b0;
        fetch_valid  = 1'b0;
        check_val("flush_valid", {31'd0, pred_valid}, 32'd0);
        check_val("flush_taken", {31'd0, pre_is_branch_taken}, 32'd0);

        // Same-cycle update and lookup of a fresh entry
        fetch_valid         = 1'b1;
        fetch_pc            = 32'h1C00_0020;
        update_en           = 1'b1;
        update_pc           = 32'h1C00_0020;
        taken_or_not_actual = 1'b1;
        branch_actual_addr  = 32'h1C00_0200;
        step();
        fetch_valid = 1'b0;
        update_en   = 1'b0;
`ifdef BPU_FWD_EN
        check_pred("same_cyc", 1'b1, 32'h1C00_0200);
`else
        check_pred("same_cyc", 1'b0, 32'h1C00_0024);
`endif
        fetch(32'h1C00_0020);
        check_pred("after_same", 1'b1, 32'h1C00_0200);

        // Update inputs ignored without update_en
        update_pc           = 32'h1C00_0030;
        taken_or_not_actual = 1'b1;
        branch_actual_addr  = 32'h1C00_0300;
        step();
        fetch(32'h1C00_0030);
        check_pred("no_upd_en", 1'b0, 32'h1C00_0034);

        // Fall-through wraps at 32 bits
        fetch(32'hFFFF_FFFC);
        check_pred("wrap", 1'b0, 32'h0000_0000);

        // Reset during a lookup discards it and clears the table
        fetch_valid = 1'b1;
        fetch_pc    = 32'h1C00_0010;
        rst         = 1'b1;
        step();
        rst         = 1'b0;
        fetch_valid = 1'b0;
        check_val("mid_rst_valid", {31'd0, pred_valid}, 32'd0);
        check_val("mid_rst_taken", {31'd0, pre_is_branch_taken}, 32'd0);
        check_val("mid_rst_addr", pre_branch_addr, 32'd0);
        fetch(32'h1C00_0010);
        check_pred("post_rst", 1'b0, 32'h1C00_0014);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
